// File: rtl/note_player.sv
// note_player
//   Plays one note at a time for song_reader. A new_note strobe latches the note
//   index and its duration in beats, then the block counts beats down and
//   returns a one-cycle note_done pulse when the note expires. On each codec
//   sample request it may advance a phase accumulator by the step from the
//   external frequency ROM. One cycle later it reports the sample, either with
//   a sine-ROM address or as a muted sample.
//
//   Optional feature: define NOTE_PLAYER_GAP_EN to insert a one-beat muted gap
//   after every note. In that build, note_done is issued when the gap ends.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   play                  1 = run, 0 = freeze beat count and phase
//   note, duration        note index (0 = rest) and length in beats
//   new_note              strobe that loads note/duration
//   beat                  beat tick
//   freq_step             phase increment for note_rom_addr (combinational ROM)
//   generate_next_sample  codec sample request
//   note_rom_addr         latched note, drives the frequency ROM
//   sample_addr           sine-ROM address taken from the top bits of phase
//   sample_valid, mute    sample pulse one cycle after each request; mute = zero sample
//   note_done             one-cycle pulse when the current note finishes
//   busy                  1 while a note (or its gap) is held
module note_player #(
   parameter int PHASE_W = 20,
   parameter int ADDR_W  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               play,
   input  logic [5:0]         note,
   input  logic [5:0]         duration,
   input  logic               new_note,
   input  logic               beat,
   input  logic [PHASE_W-1:0] freq_step,
   input  logic               generate_next_sample,
   output logic [5:0]         note_rom_addr,
   output logic [ADDR_W-1:0]  sample_addr,
   output logic               sample_valid,
   output logic               mute,
   output logic               note_done,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [5:0]          remaining_r;
   logic [PHASE_W-1:0]  phase_r;
   logic                done_next_s;
   logic                dec_s;
   logic                adv_s;

   // sine-ROM address is the top ADDR_W bits of the registered phase
   assign sample_addr = phase_r[PHASE_W-1 -: ADDR_W];

   // phase only advances for a sounding note while running; a coincident load wins
   assign adv_s = generate_next_sample && (state_r == PLAY) && play &&
                  (note_rom_addr != 6'd0) && !new_note;

   // next-state, beat decrement and note_done decision
   always_comb begin
      state_next_s = state_r;
      done_next_s  = 1'b0;
      dec_s        = 1'b0;
      case (state_r)
         IDLE: begin
            state_next_s = IDLE;
         end
         PLAY: begin
            if (beat && play) begin
               dec_s = 1'b1;
               if (remaining_r == 6'd1) begin
`ifdef NOTE_PLAYER_GAP_EN
                  state_next_s = GAP;
`else
                  state_next_s = IDLE;
                  done_next_s  = 1'b1;
`endif
               end else begin
                  state_next_s = PLAY;
               end
            end else begin
               state_next_s = PLAY;
            end
         end
`ifdef NOTE_PLAYER_GAP_EN
         GAP: begin
            if (beat && play) begin
               state_next_s = IDLE;
               done_next_s  = 1'b1;
            end else begin
               state_next_s = GAP;
            end
         end
`endif
         default: begin
            state_next_s = IDLE;
         end
      endcase
      // a load overrides the transition but keeps any done for the old note
      if (new_note) begin
         if (duration != 6'd0) begin
            state_next_s = PLAY;
         end else begin
            state_next_s = IDLE;
            done_next_s  = 1'b1;
         end
      end else begin
         dec_s = dec_s;
      end
   end

   // state, note/beat/phase registers and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         remaining_r   <= 6'd0;
         phase_r       <= '0;
         note_rom_addr <= 6'd0;
         sample_valid  <= 1'b0;
         mute          <= 1'b0;
         note_done     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         note_done    <= done_next_s;
         busy         <= (state_next_s != IDLE);
         sample_valid <= generate_next_sample;
         mute         <= !adv_s;
         if (new_note) begin
            note_rom_addr <= note;
            remaining_r   <= duration;
            phase_r       <= '0;
         end else begin
            if (dec_s) begin
               remaining_r <= remaining_r - 6'd1;
            end
            if (adv_s) begin
               phase_r <= phase_r + freq_step;
            end
         end
      end
   end

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic [5:0]  note;
   logic [5:0]  duration;
   logic        new_note;
   logic        beat;
   logic [19:0] freq_step;
   logic        generate_next_sample;
   logic [5:0]  note_rom_addr;
   logic [9:0]  sample_addr;
   logic        sample_valid;
   logic        mute;
   logic        note_done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   note_player dut (
      .clk(clk), .reset(reset), .play(play), .note(note), .duration(duration),
      .new_note(new_note), .beat(beat), .freq_step(freq_step),
      .generate_next_sample(generate_next_sample), .note_rom_addr(note_rom_addr),
      .sample_addr(sample_addr), .sample_valid(sample_valid), .mute(mute),
      .note_done(note_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs settle 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [5:0] n, input logic [5:0] d);
      note = n; duration = d; new_note = 1'b1;
      tick();
      new_note = 1'b0;
   endtask

   task automatic do_beat();
      beat = 1'b1;
      tick();
      beat = 1'b0;
   endtask

   task automatic sample();
      generate_next_sample = 1'b1;
      tick();
      generate_next_sample = 1'b0;
   endtask

   initial begin
      reset = 1'b1; play = 1'b1; note = 6'd0; duration = 6'd0; new_note = 1'b0;
      beat = 1'b0; freq_step = 20'h01000; generate_next_sample = 1'b0;
      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", note_done, 1'b0);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_addr", sample_addr, 10'd0);
      reset = 1'b0;
      tick();

      // basic note: sample addresses 4, 8, 12 then done after beat 3
      load(6'd20, 6'd3);
      check("play_busy", busy, 1'b1);
      check("play_rom_addr", note_rom_addr, 6'd20);
      for (int i = 1; i <= 3; i++) begin
         sample();
         check("play_valid", sample_valid, 1'b1);
         check("play_mute", mute, 1'b0);
         check("play_addr", sample_addr, 4 * i);
         tick();
         check("valid_one_cycle", sample_valid, 1'b0);
      end
      do_beat(); check("beat1_done", note_done, 1'b0);
      do_beat(); check("beat2_done", note_done, 1'b0);
      do_beat();
`ifdef NOTE_PLAYER_GAP_EN
      check("beat3_done_gap", note_done, 1'b0);
      check("gap_busy", busy, 1'b1);
      do_beat();
`endif
      check("final_done", note_done, 1'b1);
      check("final_busy", busy, 1'b0);
      tick();
      check("done_one_cycle", note_done, 1'b0);

      // pause: beats ignored and samples muted while play=0
      load(6'd20, 6'd3);
      sample();
      check("pause_pre_addr", sample_addr, 10'd4);
      do_beat();
      play = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_beat();
         check("pause_no_done", note_done, 1'b0);
      end
      sample();
      check("pause_mute", mute, 1'b1);
      check("pause_addr_hold", sample_addr, 10'd4);
      check("pause_busy", busy, 1'b1);
      play = 1'b1;
      do_beat(); check("resume_beat2", note_done, 1'b0);
      do_beat();
`ifdef NOTE_PLAYER_GAP_EN
      do_beat();
`endif
      check("resume_done", note_done, 1'b1);
      tick();

      // rest note: muted samples, done after 2 beats
      load(6'd0, 6'd2);
      sample();
      check("rest_valid", sample_valid, 1'b1);
      check("rest_mute", mute, 1'b1);
      do_beat(); check("rest_beat1", note_done, 1'b0);
      do_beat();
`ifdef NOTE_PLAYER_GAP_EN
      do_beat();
`endif
      check("rest_done", note_done, 1'b1);
      tick();

      // phase wrap: 3 x FFFFF -> FFFFD, top bits 3FF
      freq_step = 20'hFFFFF;
      load(6'd5, 6'd5);
      sample(); sample(); sample();
      check("wrap_addr", sample_addr, 10'h3FF);
      check("wrap_mute", mute, 1'b0);
      freq_step = 20'h01000;

      // duration 0: done next cycle, busy stays low
      load(6'd9, 6'd0);
      check("dur0_done", note_done, 1'b1);
      check("dur0_busy", busy, 1'b0);
      tick();
      check("dur0_done_clear", note_done, 1'b0);

      // new_note coincident with final beat
      load(6'd7, 6'd1);
      note = 6'd9; duration = 6'd2; new_note = 1'b1; beat = 1'b1;
      tick();
      new_note = 1'b0; beat = 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
      check("coinc_done", note_done, 1'b0);
`else
      check("coinc_done", note_done, 1'b1);
`endif
      check("coinc_busy", busy, 1'b1);
      check("coinc_rom_addr", note_rom_addr, 6'd9);
      tick();
      check("coinc_single_done", note_done, 1'b0);
      do_beat(); check("coinc_new_beat1", note_done, 1'b0);
      do_beat();
`ifdef NOTE_PLAYER_GAP_EN
      do_beat();
`endif
      check("coinc_new_done", note_done, 1'b1);

      // async reset mid-note: outputs clear without a clock edge
      load(6'd3, 6'd4);
      generate_next_sample = 1'b1;
      tick();
      generate_next_sample = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_busy", busy, 1'b0);
      check("async_valid", sample_valid, 1'b0);
      check("async_rom_addr", note_rom_addr, 6'd0);
      tick();
      reset = 1'b0;
      tick();
      check("async_no_done", note_done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
